dmem_arbiter: RTL



---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (fixed m0-first priority instead of round-robin).
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    ID_M0 = 1'b0,
    ID_M1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker producing a one-hot grant.
// With DMEM_ARB_FIXED_PRIO_EN defined m0 always wins; otherwise round-robin on the last grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifndef DMEM_ARB_FIXED_PRIO_EN
  input  req_id_t    last,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
`else
    // On a tie the requester that did not win last time goes next.
    if (req == 2'b11) begin
      gnt = (last == ID_M1) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous single-port data memory between two requesters (m0, m1),
// sequencing each access as ADDR then DATA. Macro DMEM_ARB_FIXED_PRIO_EN selects fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req and its payload until it sees gnt (one cycle,
  // during ADDR); the payload is latched by then, so it must drop req or present a
  // new payload in the following cycle, otherwise the same access is repeated.

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        req;
  logic [1:0]        pick;
  logic              take;
  logic [1:0]        gnt_q;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  req_id_t           lat_id;

  assign req  = {m1_req, m0_req};
  // Arbitration happens only at the edge leaving IDLE or DATA.
  assign take = ((state == ST_IDLE) || (state == ST_DATA)) && (req != 2'b00);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  rr_arb2 u_pick (
    .req (req),
    .gnt (pick)
  );
`else
  req_id_t last_id;

  rr_arb2 u_pick (
    .req  (req),
    .last (last_id),
    .gnt  (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id <= ID_M1;
    end else if (take) begin
      last_id <= pick[1] ? ID_M1 : ID_M0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (take) state_nxt = ST_ADDR;
      ST_ADDR: state_nxt = ST_DATA;
      ST_DATA: state_nxt = take ? ST_ADDR : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= 2'b00;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_id    <= ID_M0;
    end else begin
      gnt_q <= take ? pick : 2'b00;
      if (take) begin
        lat_id    <= pick[1] ? ID_M1 : ID_M0;
        lat_we    <= pick[1] ? m1_we : m0_we;
        lat_addr  <= pick[1] ? m1_addr : m0_addr;
        lat_wdata <= pick[1] ? m1_wdata : m0_wdata;
      end
    end
  end

  // Write strobe decodes straight from state so an async reset kills it at once.
  always_comb begin
    mem_wren  = 1'b0;
    mem_data  = '0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (state == ST_DATA) begin
      mem_wren = lat_we;
      mem_data = lat_wdata;
      if (!lat_we) begin
        if (lat_id == ID_M0) begin
          m0_rvalid = 1'b1;
          m0_rdata  = mem_q;
        end else begin
          m1_rvalid = 1'b1;
          m1_rdata  = mem_q;
        end
      end
    end
  end

  // The latched address is stable through ADDR/DATA and holds its value in IDLE.
  assign mem_addr  = lat_addr;
  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign dbg_state = state;

endmodule
